bk_sequencer: RTL and testbench

BK_SEQUENCER -- requirements
Module: bk_sequencer

---
 rtl/bk_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_bk_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bk_sequencer.sv
// Save-state sequencer: streams one slot of SECTORS sectors to or from the SD image via the hps_io ack handshake.
// Optional autosave of dirty backup RAM is enabled by defining BK_AUTOSAVE_EN.
module bk_sequencer #(
    parameter int unsigned SECTORS = 64,
    parameter int unsigned SLOTS   = 4,
    parameter int unsigned LBA_W   = 32,
    localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               ena,
    input  logic               load,
    input  logic               save,
    input  logic [SLOT_W-1:0]  slot,
    input  logic               abort,
    input  logic               sd_ack,
    input  logic               dirty_set,
    input  logic               autosave,
    output logic [LBA_W-1:0]   sd_lba,
    output logic               sd_rd,
    output logic               sd_wr,
    output logic               busy,
    output logic               loading,
    output logic               done,
    output logic               err,
    output logic               dirty
);

    localparam int unsigned IDX_W = $clog2(SECTORS);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;

    state_t              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                loading_d, busy_d, rd_d, wr_d, done_d, err_d, dirty_d;
    logic                abort_pend_q, abort_pend_d;
    logic                load_q, save_q, ack_q;

    logic                load_rise_c, save_rise_c, auto_start_c, start_c;
    logic                ack_rise_c, ack_fall_c, cancel_c, last_c;

    assign load_rise_c = load & ena & ~load_q;
    assign save_rise_c = save & ena & ~save_q;
    assign ack_rise_c  = sd_ack & ~ack_q;
    assign ack_fall_c  = ~sd_ack & ack_q;
    assign cancel_c    = abort | ~ena;
    assign last_c      = (idx_q == IDX_W'(SECTORS - 1));
    assign start_c     = load_rise_c | save_rise_c | auto_start_c;

    // Slot field sits directly above the sector index; the index never wraps into it.
    assign sd_lba = LBA_W'({slot_q, idx_q});

`ifdef BK_AUTOSAVE_EN
    logic auto_q;

    assign auto_start_c = autosave & ena & ~auto_q & dirty;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            auto_q <= 1'b0;
        end else begin
            auto_q <= autosave & ena;
        end
    end
`else
    logic unused_autosave;

    assign auto_start_c    = 1'b0;
    assign unused_autosave = dirty_set ^ autosave;
`endif

    // State and output registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            slot_q       <= '0;
            idx_q        <= '0;
            abort_pend_q <= 1'b0;
            load_q       <= 1'b0;
            save_q       <= 1'b0;
            ack_q        <= 1'b0;
            loading      <= 1'b0;
            busy         <= 1'b0;
            sd_rd        <= 1'b0;
            sd_wr        <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            dirty        <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            idx_q        <= idx_d;
            abort_pend_q <= abort_pend_d;
            load_q       <= load & ena;
            save_q       <= save & ena;
            ack_q        <= sd_ack;
            loading      <= loading_d;
            busy         <= busy_d;
            sd_rd        <= rd_d;
            sd_wr        <= wr_d;
            done         <= done_d;
            err          <= err_d;
            dirty        <= dirty_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        idx_d        = idx_q;
        abort_pend_d = abort_pend_q;
        loading_d    = loading;
        busy_d       = busy;
        rd_d         = sd_rd;
        wr_d         = sd_wr;
        done_d       = 1'b0;
        err_d        = err;

        case (state_q)
            S_IDLE: begin
                // Load beats save, and both beat autosave
                if (start_c) begin
                    slot_d       = slot;
                    idx_d        = '0;
                    loading_d    = load_rise_c;
                    busy_d       = 1'b1;
                    err_d        = 1'b0;
                    rd_d         = load_rise_c;
                    wr_d         = ~load_rise_c;
                    abort_pend_d = 1'b0;
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                if (cancel_c) begin
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                    busy_d    = 1'b0;
                    loading_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_IDLE;
                end else if (ack_rise_c) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                // A cancel here waits for the ack to fall so hps_io finishes its sector
                if (cancel_c) begin
                    abort_pend_d = 1'b1;
                end
                if (ack_fall_c) begin
                    if (abort_pend_q || cancel_c) begin
                        busy_d       = 1'b0;
                        loading_d    = 1'b0;
                        err_d        = 1'b1;
                        abort_pend_d = 1'b0;
                        state_d      = S_IDLE;
                    end else if (last_c) begin
                        busy_d    = 1'b0;
                        loading_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        rd_d    = loading;
                        wr_d    = ~loading;
                        state_d = S_REQ;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Dirty tracking
    always_comb begin
        dirty_d = 1'b0;
`ifdef BK_AUTOSAVE_EN
        dirty_d = dirty;
        if (done_d && loading) begin
            dirty_d = 1'b0;
        end else if (dirty_set) begin
            dirty_d = 1'b1;
        end else if (done_d) begin
            dirty_d = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_bk_sequencer.sv
// Directed bench for bk_sequencer: save/load streams, priority, discard-while-busy, abort paths, reset, autosave.
module tb_bk_sequencer;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ena, load, save, abort, sd_ack, dirty_set, autosave;
    logic [1:0]  slot;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, busy, loading, done, err, dirty;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_sys = ~clk_sys;

    bk_sequencer dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ena       (ena),
        .load      (load),
        .save      (save),
        .slot      (slot),
        .abort     (abort),
        .sd_ack    (sd_ack),
        .dirty_set (dirty_set),
        .autosave  (autosave),
        .sd_lba    (sd_lba),
        .sd_rd     (sd_rd),
        .sd_wr     (sd_wr),
        .busy      (busy),
        .loading   (loading),
        .done      (done),
        .err       (err),
        .dirty     (dirty)
    );

    // Request monitor: logs the lba of every new request and counts events
    logic        req_prev = 1'b0;
    logic [31:0] lba_q[$];
    int          rd_rises = 0, wr_rises = 0, done_cnt = 0, noload_cnt = 0;
    logic        load_op = 1'b0;

    always @(negedge clk_sys) begin
        if ((sd_rd | sd_wr) && !req_prev) begin
            lba_q.push_back(sd_lba);
            if (sd_rd) rd_rises++;
            if (sd_wr) wr_rises++;
        end
        req_prev = sd_rd | sd_wr;
        if (done) done_cnt++;
        if (load_op && busy && !loading) noload_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Acknowledge n sector requests, ack high for one cycle each
    task automatic serve(input int n);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            while (!(sd_rd | sd_wr) && w < 20) begin
                tick();
                w++;
            end
            if (w >= 20) begin
                chk("req_timeout", 64'd0, 64'd1);
                return;
            end
            sd_ack = 1'b1;
            tick();
            sd_ack = 1'b0;
            tick();
        end
    endtask

    task automatic chk_lbas(input string tag, input int base, input int n, input logic [31:0] first);
        int bad = 0;
        if (lba_q.size() != base + n) bad++;
        for (int i = 0; i < n && base + i < lba_q.size(); i++)
            if (lba_q[base + i] !== first + 32'(i)) bad++;
        chk(tag, 64'(bad), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b, w0, r0, d0;
        reset_n = 1'b0; ena = 1'b0; load = 1'b0; save = 1'b0; abort = 1'b0;
        sd_ack = 1'b0; dirty_set = 1'b0; autosave = 1'b0; slot = 2'd0;
        tick(); tick();
        chk("rst_outs", {sd_lba, sd_rd, sd_wr, busy, loading, done, err, dirty}, 64'd0);
        reset_n = 1'b1;
        ena = 1'b1;
        tick();

        // Save slot 2
        slot = 2'd2; b = lba_q.size(); w0 = wr_rises; r0 = rd_rises; d0 = done_cnt;
        save = 1'b1; tick(); save = 1'b0;
        chk("save_start", {busy, loading, sd_wr, sd_rd}, 64'b1010);
        chk("save_lba0", sd_lba, 64'd128);
        serve(64);
        chk("save_done", {done, busy}, 64'b10);
        tick();
        chk("save_done_pulse", done, 64'd0);
        chk("save_wr_cnt", 64'(wr_rises - w0), 64'd64);
        chk("save_rd_cnt", 64'(rd_rises - r0), 64'd0);
        chk("save_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk_lbas("save_lbas", b, 64, 32'd128);

        // Load slot 3
        slot = 2'd3; b = lba_q.size(); w0 = wr_rises; r0 = rd_rises;
        load_op = 1'b1; load = 1'b1; tick();
        chk("load_start", {busy, loading, sd_wr, sd_rd}, 64'b1101);
        chk("load_lba0", sd_lba, 64'd192);
        serve(64);
        chk("load_done", {done, loading, busy}, 64'b100);
        load = 1'b0; load_op = 1'b0;
        chk("load_rd_cnt", 64'(rd_rises - r0), 64'd64);
        chk("load_wr_cnt", 64'(wr_rises - w0), 64'd0);
        chk("load_held", 64'(noload_cnt), 64'd0);
        chk_lbas("load_lbas", b, 64, 32'd192);
        tick();

        // Simultaneous load+save, then a save edge while busy
        slot = 2'd1; b = lba_q.size(); w0 = wr_rises; r0 = rd_rises;
        load = 1'b1; save = 1'b1; tick();
        chk("both_load_wins", {loading, sd_rd, sd_wr}, 64'b110);
        serve(5);
        save = 1'b0; tick(); save = 1'b1; tick();
        serve(59);
        chk("both_done", done, 64'd1);
        tick(); tick(); tick();
        chk("busy_edge_dropped", busy, 64'd0);
        chk("both_rd_cnt", 64'(rd_rises - r0), 64'd64);
        chk("both_wr_cnt", 64'(wr_rises - w0), 64'd0);
        chk_lbas("both_lbas", b, 64, 32'd64);
        load = 1'b0; save = 1'b0; tick();

        // Abort while in REQ at index 10
        slot = 2'd0; w0 = wr_rises; d0 = done_cnt;
        save = 1'b1; tick(); save = 1'b0;
        serve(10);
        chk("abreq_at10", {sd_wr, sd_lba}, {1'b1, 32'd10});
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abreq_outs", {sd_wr, sd_rd, busy, loading, err}, 64'b00001);
        tick(); tick(); tick();
        chk("abreq_no_done", 64'(done_cnt - d0), 64'd0);
        chk("abreq_wr_cnt", 64'(wr_rises - w0), 64'd11);

        // Abort during XFER at index 10
        w0 = wr_rises; d0 = done_cnt;
        save = 1'b1; tick(); save = 1'b0;
        chk("abx_err_clr", {err, busy}, 64'b01);
        serve(10);
        sd_ack = 1'b1; tick();
        abort = 1'b1; tick(); abort = 1'b0; tick();
        chk("abx_waits", {busy, err, sd_wr}, 64'b100);
        sd_ack = 1'b0; tick();
        chk("abx_end", {busy, err, done}, 64'b010);
        tick(); tick(); tick();
        chk("abx_wr_cnt", 64'(wr_rises - w0), 64'd11);
        chk("abx_no_done", 64'(done_cnt - d0), 64'd0);

        // Ack in IDLE is ignored
        sd_ack = 1'b1; tick(); sd_ack = 1'b0; tick(); tick();
        chk("idle_ack", {busy, sd_rd, sd_wr}, 64'b000);

`ifdef BK_AUTOSAVE_EN
        dirty_set = 1'b1; tick(); dirty_set = 1'b0;
        chk("dirty_set", dirty, 64'd1);
        slot = 2'd0; b = lba_q.size();
        autosave = 1'b1; tick(); autosave = 1'b0;
        chk("auto_start", {busy, sd_wr, loading}, 64'b110);
        serve(64);
        chk("auto_done", {done, dirty}, 64'b10);
        chk_lbas("auto_lbas", b, 64, 32'd0);
        w0 = wr_rises;
        autosave = 1'b1; tick(); tick(); autosave = 1'b0;
        chk("auto_clean_idle", busy, 64'd0);
        chk("auto_clean_no_req", 64'(wr_rises - w0), 64'd0);
`else
        w0 = wr_rises;
        dirty_set = 1'b1; tick(); dirty_set = 1'b0;
        chk("dirty_tied", dirty, 64'd0);
        autosave = 1'b1; tick(); tick(); autosave = 1'b0;
        chk("auto_ignored", busy, 64'd0);
        chk("auto_no_req", 64'(wr_rises - w0), 64'd0);
`endif
        tick();

        // Reset mid-XFER, load held through release
        slot = 2'd2;
        load = 1'b1; tick();
        serve(3);
        sd_ack = 1'b1; tick();
        reset_n = 1'b0; #1; sd_ack = 1'b0;
        chk("rst_async", {sd_lba, sd_rd, sd_wr, busy, loading, done, err, dirty}, 64'd0);
        tick(); tick();
        reset_n = 1'b1;
        b = lba_q.size();
        tick();
        chk("rst_reload", {busy, loading, sd_rd}, 64'b111);
        chk("rst_reload_lba", sd_lba, 64'd128);
        serve(64);
        chk("rst_reload_done", {done, busy}, 64'b10);
        chk_lbas("rst_reload_lbas", b, 64, 32'd128);
        load = 1'b0; tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
